// File: rtl/jtshouse_scr_rom_if.sv
// Scroll tile fetch bus bundle: renderer byte-read port plus SDRAM line-burst port.
//   master: renderer + SDRAM slot side (drives scr_cs/scr_addr, rom_ack/rom_dst/rom_data)
//   slave : cache side (drives scr_ok/scr_data, rom_req/rom_addr)
interface jtshouse_scr_rom_if #(
    parameter int unsigned AW = 20
);
    logic          scr_cs;
    logic [AW-1:0] scr_addr;
    logic          scr_ok;
    logic [7:0]    scr_data;
    logic          rom_req;
    logic [AW-2:0] rom_addr;
    logic          rom_ack;
    logic          rom_dst;
    logic [15:0]   rom_data;

    modport master (
        output scr_cs, scr_addr,
        input  scr_ok, scr_data,
        input  rom_req, rom_addr,
        output rom_ack, rom_dst, rom_data
    );

    modport slave (
        input  scr_cs, scr_addr,
        output scr_ok, scr_data,
        output rom_req, rom_addr,
        input  rom_ack, rom_dst, rom_data
    );
endinterface

// File: rtl/jtshouse_scr_rom.sv
// Scroll tile-pixel line cache: serves renderer byte reads from a small fully
// associative cache of 8-byte tile rows, refilling misses from SDRAM in 4-halfword bursts.
//   rst, clk   : async active-high reset, system clock
//   flush_i    : invalidate all lines, drop any in-flight fill, block new fills
//   bus        : slave side of the renderer / SDRAM bundle
//   st_miss_o  : saturating miss counter
module jtshouse_scr_rom #(
    parameter int unsigned LINES = 2,
    parameter int unsigned AW    = 20
) (
    input  logic                rst,
    input  logic                clk,
    input  logic                flush_i,
    jtshouse_scr_rom_if.slave   bus,
    output logic [7:0]          st_miss_o
);
    localparam int unsigned TW = AW - 3;
    localparam int unsigned LW = (LINES > 2) ? 2 : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          req_q, req_d;
    logic [AW-2:0] raddr_q, raddr_d;
    logic [LW-1:0] victim_q, victim_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [1:0]    wc_q, wc_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic          drop_q, drop_d;
    logic [7:0]    miss_q, miss_d;
    logic [AW-1:0] addr_l_q;
    logic          hit_l_q;
    logic [7:0]    data_l_q;

    logic [TW-1:0] tag_q [LINES];
    logic [15:0]   mem_q [LINES][4];

    logic [TW-1:0] cur_tag_c;
    logic          hit_c;
    logic [15:0]   hit_word_c;
    logic [7:0]    hit_byte_c;
    logic          start_c;

    assign cur_tag_c = bus.scr_addr[AW-1:3];

    // Tag match; misses never duplicate a resident tag, so at most one line hits.
    always_comb begin
        hit_c      = 1'b0;
        hit_word_c = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid_q[i] && (tag_q[i] == cur_tag_c)) begin
                hit_c      = 1'b1;
                hit_word_c = mem_q[i][bus.scr_addr[2:1]];
            end
        end
    end

    assign hit_byte_c = bus.scr_addr[0] ? hit_word_c[15:8] : hit_word_c[7:0];

    // Fill FSM next-state; flush overrides valid bits and pointer last.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        raddr_d  = raddr_q;
        victim_d = victim_q;
        ptr_d    = ptr_q;
        wc_d     = wc_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        miss_d   = miss_q;
        start_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.scr_cs && !hit_c && !flush_i) begin
                    start_c         = 1'b1;
                    state_d         = ST_REQ;
                    req_d           = 1'b1;
                    raddr_d         = {cur_tag_c, 2'b00};
                    victim_d        = ptr_q;
                    valid_d[ptr_q]  = 1'b0;
                    drop_d          = 1'b0;
                    if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                end
            end
            ST_REQ: begin
                if (bus.rom_ack) begin
                    state_d = ST_BURST;
                    req_d   = 1'b0;
                    wc_d    = 2'd0;
                end
            end
            ST_BURST: begin
                if (bus.rom_dst) begin
                    wc_d = wc_q + 2'd1;
                    if (wc_q == 2'd3) begin
                        state_d = ST_IDLE;
                        if (!drop_q) valid_d[victim_q] = 1'b1;
                        ptr_d = LW'(ptr_q + 1'b1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            valid_d = '0;
            ptr_d   = '0;
            if (state_q != ST_IDLE) drop_d = 1'b1;
        end
    end

    // Control and lookup registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            raddr_q  <= '0;
            victim_q <= '0;
            ptr_q    <= '0;
            wc_q     <= 2'd0;
            valid_q  <= '0;
            drop_q   <= 1'b0;
            miss_q   <= 8'd0;
            addr_l_q <= '0;
            hit_l_q  <= 1'b0;
            data_l_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            raddr_q  <= raddr_d;
            victim_q <= victim_d;
            ptr_q    <= ptr_d;
            wc_q     <= wc_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            miss_q   <= miss_d;
            addr_l_q <= bus.scr_addr;
            hit_l_q  <= hit_c;
            if (hit_c) data_l_q <= hit_byte_c;
        end
    end

    // Line storage; contents are qualified by valid bits so no reset is needed.
    always_ff @(posedge clk) begin
        if (start_c) tag_q[ptr_q] <= cur_tag_c;
        if (state_q == ST_BURST && bus.rom_dst) mem_q[victim_q][wc_q] <= bus.rom_data;
    end

    // Data is only flagged valid when the address has been stable for a full cycle.
    assign bus.scr_ok   = bus.scr_cs & hit_l_q & (bus.scr_addr == addr_l_q);
    assign bus.scr_data = data_l_q;
    assign bus.rom_req  = req_q;
    assign bus.rom_addr = raddr_q;
    assign st_miss_o    = miss_q;
endmodule

// File: tb/tb_jtshouse_scr_rom.sv
// Directed bench for the scroll tile line cache (LINES=2, AW=20).
module tb_jtshouse_scr_rom;
    localparam int unsigned AW = 20;

    logic       clk;
    logic       rst;
    logic       flush_i;
    logic [7:0] st_miss_o;
    int         checks   = 0;
    int         failures = 0;

    jtshouse_scr_rom_if #(.AW(AW)) bus ();

    jtshouse_scr_rom #(.LINES(2), .AW(AW)) dut (
        .rst       (rst),
        .clk       (clk),
        .flush_i   (flush_i),
        .bus       (bus.slave),
        .st_miss_o (st_miss_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are checked and inputs driven on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a line request, then ack and deliver four halfwords.
    task automatic serve(input logic [18:0] exp_addr, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        int n;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        n = 0;
        while (bus.rom_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("serve_req", 32'(bus.rom_req), 32'(1));
        chk("serve_addr", 32'(bus.rom_addr), 32'(exp_addr));
        bus.rom_ack = 1'b1;
        cyc();
        bus.rom_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.rom_dst  = 1'b1;
            bus.rom_data = d[k];
            cyc();
        end
        bus.rom_dst = 1'b0;
    endtask

    initial begin
        logic [19:0] a;
        rst          = 1'b1;
        flush_i      = 1'b0;
        bus.scr_cs   = 1'b0;
        bus.scr_addr = '0;
        bus.rom_ack  = 1'b0;
        bus.rom_dst  = 1'b0;
        bus.rom_data = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_req", 32'(bus.rom_req), 32'(0));
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'(0));
        chk("rst_ok", 32'(bus.scr_ok), 32'(0));
        chk("rst_data", 32'(bus.scr_data), 32'(0));
        chk("rst_miss", 32'(st_miss_o), 32'(0));

        // First miss at 0x00123
        bus.scr_cs   = 1'b1;
        bus.scr_addr = 20'h00123;
        cyc();
        chk("miss_req", 32'(bus.rom_req), 32'(1));
        chk("miss_addr", 32'(bus.rom_addr), 32'h90);
        chk("miss_cnt1", 32'(st_miss_o), 32'(1));
        cyc();
        cyc();
        chk("req_hold", 32'(bus.rom_req), 32'(1));
        bus.rom_ack = 1'b1;
        cyc();
        bus.rom_ack = 1'b0;
        chk("req_drop_on_ack", 32'(bus.rom_req), 32'(0));
        for (int k = 0; k < 4; k++) begin
            bus.rom_dst  = 1'b1;
            bus.rom_data = 16'((k * 2 + 1) * 16'h1100 + (k * 2) * 16'h0011);
            cyc();
        end
        bus.rom_dst = 1'b0;
        chk("fill_ok_not_yet", 32'(bus.scr_ok), 32'(0));
        cyc();
        chk("fill_ok", 32'(bus.scr_ok), 32'(1));
        chk("fill_data", 32'(bus.scr_data), 32'h33);

        // Hit sweep across the line
        for (int i = 0; i < 8; i++) begin
            bus.scr_addr = 20'h00120 + 20'(i);
            #1;
            chk("sweep_ok_changed", 32'(bus.scr_ok), 32'(0));
            cyc();
            chk("sweep_ok", 32'(bus.scr_ok), 32'(1));
            chk("sweep_data", 32'(bus.scr_data), 32'(i * 17));
            chk("sweep_noreq", 32'(bus.rom_req), 32'(0));
        end

        // Replacement with two lines
        bus.scr_addr = 20'h00200;
        serve(19'h100, 16'hA1A0, 16'hA3A2, 16'hA5A4, 16'hA7A6);
        bus.scr_addr = 20'h00300;
        serve(19'h180, 16'hB1B0, 16'hB3B2, 16'hB5B4, 16'hB7B6);
        bus.scr_addr = 20'h00201;
        cyc();
        chk("repl_200_ok", 32'(bus.scr_ok), 32'(1));
        chk("repl_200_data", 32'(bus.scr_data), 32'hA1);
        chk("repl_200_noreq", 32'(bus.rom_req), 32'(0));
        bus.scr_addr = 20'h00302;
        cyc();
        chk("repl_300_data", 32'(bus.scr_data), 32'hB2);
        bus.scr_addr = 20'h00120;
        cyc();
        chk("repl_120_miss", 32'(bus.rom_req), 32'(1));
        chk("repl_120_ok", 32'(bus.scr_ok), 32'(0));
        chk("repl_miss_cnt", 32'(st_miss_o), 32'(4));
        serve(19'h090, 16'h1100, 16'h3322, 16'h5544, 16'h7766);
        bus.scr_addr = 20'h00125;
        cyc();
        chk("refill_120_data", 32'(bus.scr_data), 32'h55);

        // Flush in the middle of a burst
        bus.scr_addr = 20'h00400;
        cyc();
        chk("fl_req", 32'(bus.rom_req), 32'(1));
        chk("fl_addr", 32'(bus.rom_addr), 32'h200);
        bus.rom_ack = 1'b1;
        cyc();
        bus.rom_ack = 1'b0;
        bus.rom_dst = 1'b1; bus.rom_data = 16'hC1C0; cyc();
        bus.rom_dst = 1'b1; bus.rom_data = 16'hC3C2; cyc();
        bus.rom_dst = 1'b0;
        flush_i     = 1'b1;
        cyc();
        flush_i     = 1'b0;
        bus.rom_dst = 1'b1; bus.rom_data = 16'hC5C4; cyc();
        bus.rom_dst = 1'b1; bus.rom_data = 16'hC7C6; cyc();
        bus.rom_dst = 1'b0;
        chk("fl_done_noreq", 32'(bus.rom_req), 32'(0));
        cyc();
        chk("fl_refetch_req", 32'(bus.rom_req), 32'(1));
        chk("fl_refetch_ok", 32'(bus.scr_ok), 32'(0));
        chk("fl_miss_cnt", 32'(st_miss_o), 32'(6));
        serve(19'h200, 16'hD1D0, 16'hD3D2, 16'hD5D4, 16'hD7D6);
        cyc();
        chk("fl_refill_ok", 32'(bus.scr_ok), 32'(1));
        chk("fl_refill_data", 32'(bus.scr_data), 32'hD0);
        bus.scr_addr = 20'h00121;
        cyc();
        chk("fl_120_gone", 32'(bus.rom_req), 32'(1));
        serve(19'h090, 16'h1100, 16'h3322, 16'h5544, 16'h7766);

        // Miss counter saturation
        for (int i = 0; i < 300; i++) begin
            a = 20'h10000 + 20'(i * 8);
            bus.scr_addr = a;
            serve(19'(a >> 1), 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        end
        chk("sat_cnt", 32'(st_miss_o), 32'd255);

        // Reset in REQ, then stray burst
        bus.scr_addr = 20'h00500;
        cyc();
        chk("rr_req", 32'(bus.rom_req), 32'(1));
        chk("rr_addr", 32'(bus.rom_addr), 32'h280);
        rst = 1'b1;
        #1;
        chk("rr_async_req", 32'(bus.rom_req), 32'(0));
        chk("rr_async_cnt", 32'(st_miss_o), 32'(0));
        cyc();
        rst        = 1'b0;
        bus.scr_cs = 1'b0;
        bus.rom_ack = 1'b1;
        cyc();
        bus.rom_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.rom_dst  = 1'b1;
            bus.rom_data = 16'hEEEE;
            cyc();
        end
        bus.rom_dst = 1'b0;
        chk("rr_stray_noreq", 32'(bus.rom_req), 32'(0));
        bus.scr_cs = 1'b1;
        cyc();
        chk("rr_nofill_req", 32'(bus.rom_req), 32'(1));
        chk("rr_nofill_ok", 32'(bus.scr_ok), 32'(0));
        chk("rr_cnt", 32'(st_miss_o), 32'(1));

        // Flush coinciding with the last halfword
        bus.rom_ack = 1'b1;
        cyc();
        bus.rom_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.rom_dst  = 1'b1;
            bus.rom_data = 16'h5A5A;
            if (k == 3) flush_i = 1'b1;
            cyc();
        end
        bus.rom_dst = 1'b0;
        flush_i     = 1'b0;
        chk("fl4_idle_noreq", 32'(bus.rom_req), 32'(0));
        cyc();
        chk("fl4_refetch_req", 32'(bus.rom_req), 32'(1));
        chk("fl4_ok", 32'(bus.scr_ok), 32'(0));
        chk("fl4_cnt", 32'(st_miss_o), 32'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtshouse_scr_rom.md
Name: jtshouse_scr_rom

Overview:
- Responder side of the scroll tile-pixel fetch interface: serves byte reads (scr_cs/scr_addr to scr_ok/scr_data) issued by the C123 tilemap renderer.
- Holds a small fully-associative cache of tile-row lines. Each line is 8 bytes, one 8-pixel row of an 8bpp tile.
- Misses are refilled from the SDRAM tile ROM through a 16-bit request/ack/data-strobe burst port.
- Sits between the scroll renderer and the SDRAM controller slot. It absorbs SDRAM latency so the renderer's horizontal counter stalls only on row changes.

Parameters:
- LINES, 2: number of cache lines. Legal values are 2 or 4.
- AW, 20: byte address width of the scroll ROM.

Ports:
- rst  in  1  asynchronous, active-high reset
- clk  in  1  system clock
- flush  in  1  invalidate all lines; level, sampled every clk
- scr_cs  in  1  renderer read enable
- scr_addr  in  AW  renderer byte address
- scr_ok  out  1  scr_data valid for the scr_addr currently presented
- scr_data  out  8  pixel byte
- rom_req  out  1  SDRAM line request; held until rom_ack
- rom_addr  out  AW-1  halfword address of line start, = {line_tag, 2'b00}
- rom_ack  in  1  one-cycle pulse: request accepted, burst follows
- rom_dst  in  1  one-cycle pulse per delivered halfword
- rom_data  in  16  halfword; [7:0] is the even byte, [15:8] the odd byte
- st_miss  out  8  saturating miss counter, for debug

Behaviour:
- Reset state: rom_req=0, rom_addr=0, scr_ok=0, scr_data=0, st_miss=0. All valid bits are 0, the replacement pointer is 0, and the FSM is IDLE.
- Line layout: tag = scr_addr[AW-1:3]. Byte select = scr_addr[2:0]. Storage holds 4 halfwords per line.
- Hit detection: a line hits when it is valid and its tag equals scr_addr[AW-1:3].
  - On each clk: addr_l <= scr_addr, hit_l <= any hit, data_l <= selected byte of the hitting line.
  - scr_ok = scr_cs & hit_l & (scr_addr == addr_l). This is combinational from the registered state.
  - Hit latency is one clk after the address becomes stable. scr_ok is never high for an address that changed this cycle.
  - scr_data = data_l. It holds its last value when scr_ok=0.
- FSM states: IDLE, REQ, BURST.
  - IDLE to REQ: scr_cs=1, no line hits, flush=0.
    - Latch the tag and set victim = replacement pointer.
    - rom_addr <= {tag,2'b00}, rom_req <= 1.
    - Clear the victim's valid bit.
    - st_miss increments and saturates at 255.
  - REQ to BURST: on rom_ack. rom_req <= 0 in the same edge. The word counter wc is set to 0.
  - BURST: each rom_dst writes rom_data into victim halfword wc, then wc increments.
    - On the 4th rom_dst the FSM returns to IDLE.
    - The victim's valid bit is set unless a flush was seen during this fetch.
    - The replacement pointer advances, modulo LINES.
  - rom_dst while in IDLE or REQ is ignored.
- A miss is decided only in IDLE. Address changes during REQ/BURST do not alter the in-flight fetch. The new address is compared after return to IDLE.
- scr_cs=0 in IDLE starts no fetch. scr_cs dropping mid-fetch does not abort the fetch.
- flush=1:
  - Clears all valid bits in the same edge.
  - Marks any in-flight fetch as dropped. The burst is consumed but the line is left invalid.
  - Blocks new fetches while high.
  - The replacement pointer is reset to 0.
- flush and the 4th rom_dst in the same cycle: flush wins and the line stays invalid.
- A miss cannot duplicate a resident tag, so at most one line matches at any time.
- rst asserted mid-burst: all state returns to reset values immediately. rom_req drops asynchronously. Subsequent stray rom_dst pulses are ignored in IDLE.
- Address wrap: no special case. The top line (tag all ones) is fetched like any other.

Test Plan:
- Reset check: assert rst with clk running, then release -> rom_req=0, scr_ok=0, st_miss=0. Present scr_addr=0x00123 with scr_cs=1 -> rom_req rises on the next edge with rom_addr=0x00090.
- Miss then fill: scr_addr=0x00123. Ack after 3 cycles, then 4 rom_dst with 0x1100, 0x3322, 0x5544, 0x7766 -> rom_req stays high until ack. scr_ok rises one clk after FSM returns to IDLE, with scr_data=0x33. st_miss=1.
- Hits: sweep scr_addr 0x120..0x127, one per cycle -> each byte 00,11,...,77 appears with scr_ok exactly one clk after presentation. No rom_req.
- Replacement (LINES=2): fill lines for 0x120, 0x200, then 0x300 -> the 0x300 fetch evicts the 0x120 line. A following read of 0x120 misses, and 0x200 still hits. st_miss=4.
- Flush mid-burst: pulse flush after the 2nd rom_dst, then finish the burst -> no valid line remains. Re-reading the same address issues a new rom_req.
- Saturation and reset mid-fetch: 300 distinct misses -> st_miss=255. Assert rst during REQ -> rom_req=0 immediately, and the later rom_dst pulses cause no fill.
